// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory front end: optional boot-load of program words through a
// valid/ready stream, then program-counter sequencing with redirect and halt.
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_en,
  input  logic              prog_valid,
  input  logic [31:0]       prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       pc_current,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_req,
  input  logic              resume,
  output logic [1:0]        state_o,
  output logic              misalign_err,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_t            state, state_nxt;
  logic [31:0]       pc, pc_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              err, err_nxt;
  logic              misaligned;

  assign misaligned   = (redirect_pc[1:0] != 2'b00);
  assign pc_current   = pc;
  assign state_o      = state;
  assign misalign_err = err;
  assign load_count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      pc    <= RESET_PC;
      ptr   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    err_nxt     = err;
    prog_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    fetch_valid = 1'b0;

    case (state)
      INIT: begin
        state_nxt = boot_en ? LOAD : RUN;
      end

      LOAD: begin
        prog_ready = 1'b1;
        mem_we     = prog_valid;
        mem_waddr  = ptr;
        mem_wdata  = prog_data;
        if (prog_valid) begin
          cnt_nxt = cnt + (ADDR_W+1)'(1);
          // A full memory ends the load even without a last marker.
          if (prog_last || (ptr == PTR_LAST)) begin
            state_nxt = RUN;
            pc_nxt    = RESET_PC;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = ptr + ADDR_W'(1);
          end
        end
      end

      RUN: begin
        fetch_valid = 1'b1;
        if (redirect_valid && misaligned) begin
          err_nxt   = 1'b1;
          state_nxt = HALT;
        end else begin
          if (redirect_valid) begin
            pc_nxt = redirect_pc;
          end else if (fetch_ready) begin
            pc_nxt = pc + 32'd4;
          end
          if (halt_req) begin
            state_nxt = HALT;
          end
        end
      end

      HALT: begin
        // A misaligned redirect locks the core in HALT until reset.
        if (resume && !err) begin
          state_nxt = RUN;
        end
      end

      default: begin
        state_nxt = INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios followed by random
// run traffic, checked against a transaction-level model of writes and fetches.
module tb_imem_fetch_ctrl;

  localparam int          ADDR_W   = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              boot_en = 1'b0;
  logic              prog_valid = 1'b0;
  logic [31:0]       prog_data = '0;
  logic              prog_last = 1'b0;
  logic              prog_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       pc_current;
  logic              fetch_valid;
  logic              fetch_ready = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              halt_req = 1'b0;
  logic              resume = 1'b0;
  logic [1:0]        state_o;
  logic              misalign_err;
  logic [ADDR_W:0]   load_count;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .boot_en(boot_en),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_last(prog_last),
    .prog_ready(prog_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .pc_current(pc_current), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .resume(resume),
    .state_o(state_o), .misalign_err(misalign_err), .load_count(load_count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] fq[$];
  wr_t         mon_w;
  logic [31:0] mon_pc;
  int          checks = 0;
  int          passes = 0;

  // Reference model: 0 = no fetching (init/load), 1 = running, 2 = halted.
  int          m_phase = 0;
  logic [31:0] m_pc = RESET_PC;
  bit          m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
    else passes++;
  endtask

  // Monitor: every write or consumed fetch the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_we === 1'b1) begin
        if (wq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_waddr, mem_wdata);
        end else begin
          mon_w = wq.pop_front();
          check("write_addr", 32'(mem_waddr), 32'(mon_w.a));
          check("write_data", mem_wdata, mon_w.d);
        end
      end
      if (fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
        if (fq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_fetch: got pc %h, required no fetch", pc_current);
        end else begin
          mon_pc = fq.pop_front();
          check("fetch_pc", pc_current, mon_pc);
        end
      end
    end
  end

  task automatic step(input bit fr, input bit rv, input logic [31:0] rpc, input bit hr,
                      input bit rs, input bit pv, input logic [31:0] pd, input bit pl);
    @(posedge clk);
    #1;
    if (m_phase != 0) begin
      check("state", 32'(state_o), (m_phase == 1) ? 32'd2 : 32'd3);
      check("pc", pc_current, m_pc);
      check("misalign_err", 32'(misalign_err), 32'(m_err));
      check("fetch_valid", 32'(fetch_valid), (m_phase == 1) ? 32'd1 : 32'd0);
    end
    fetch_ready    = fr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    resume         = rs;
    prog_valid     = pv;
    prog_data      = pd;
    prog_last      = pl;
    if (m_phase == 1) begin
      if (fr) fq.push_back(m_pc);
      if (rv && rpc[1:0] != 2'b00) begin
        m_err   = 1'b1;
        m_phase = 2;
      end else begin
        if (rv) m_pc = rpc;
        else if (fr) m_pc = m_pc + 32'd4;
        if (hr) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (rs && !m_err) m_phase = 1;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input bit boot);
    @(negedge clk);
    #1;
    fetch_ready = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    prog_valid = 1'b0; prog_last = 1'b0; boot_en = boot;
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pc", pc_current, RESET_PC);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_misalign_err", 32'(misalign_err), 32'd0);
    check("rst_outputs", {29'd0, fetch_valid, prog_ready, mem_we}, 32'd0);
    check("leftover_fetch", fq.size(), 32'd0);
    check("leftover_write", wq.size(), 32'd0);
    fq.delete();
    wq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("init_state", 32'(state_o), 32'd0);
    m_phase = boot ? 0 : 1;
    m_pc    = RESET_PC;
    m_err   = 1'b0;
  endtask

  // Expected writes: word i lands at address i; the load ends after n words.
  task automatic load_program(input int n, input bit use_last, input bit expect_end);
    logic [31:0] w;
    wr_t         e;
    idle();
    check("load_state", 32'(state_o), 32'd1);
    check("load_prog_ready", 32'(prog_ready), 32'd1);
    check("load_fetch_valid", 32'(fetch_valid), 32'd0);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) idle();
      w   = (n == 12) ? (32'h0010_0093 + 32'(i) * 32'h0010_0000) : $urandom;
      e.a = ADDR_W'(i);
      e.d = w;
      wq.push_back(e);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, w, use_last && (i == n - 1));
    end
    if (expect_end) begin
      idle();
      check("load_end_state", 32'(state_o), 32'd2);
      check("load_end_pc", pc_current, RESET_PC);
      check("load_count", 32'(load_count), 32'(n));
      check("load_end_prog_ready", 32'(prog_ready), 32'd0);
      m_phase = 1;
      m_pc    = RESET_PC;
    end
  endtask

  initial begin
    logic [31:0] rpc;

    // Plain boot into RUN with steady fetches.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    check("t1_pc16", pc_current, 32'h10);

    // Boot-load 12 words with gaps, then walk to 0x24 and redirect while stalled.
    do_reset(1'b1);
    load_program(12, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h2C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    check("t3_pc30", pc_current, 32'h30);

    // Misaligned redirect locks HALT; resume is ignored; reset clears the flag.
    step(1'b0, 1'b1, 32'h2E, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle();
    check("t4_err", 32'(misalign_err), 32'd1);
    check("t4_state", 32'(state_o), 32'd3);
    do_reset(1'b0);

    // Halt with a concurrent fetch advance, then resume.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    idle();
    check("t5_pc12", pc_current, 32'hC);
    check("t5_state_run", 32'(state_o), 32'd2);
    // Aligned redirect and halt in the same cycle: redirect applies, then HALT.
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle();

    // Aborted load restarts at address 0 with a fresh count.
    do_reset(1'b1);
    load_program(5, 1'b0, 1'b0);
    do_reset(1'b1);
    load_program(3, 1'b1, 1'b1);

    // Full-memory load without a last marker; trailing prog words are ignored.
    do_reset(1'b1);
    load_program(256, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    check("t6_wrap", pc_current, 32'h0);

    // Random traffic in RUN/HALT with occasional resets and short reloads.
    for (int k = 0; k < 1500; k++) begin
      if (m_err && $urandom_range(0, 7) == 0) begin
        do_reset(1'b0);
      end else if ($urandom_range(0, 199) == 0) begin
        do_reset(1'b1);
        load_program($urandom_range(1, 16), 1'b1, 1'b1);
      end else begin
        rpc      = $urandom;
        rpc[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rpc,
             $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1) == 1);
      end
    end
    idle();
    @(negedge clk);
    #1;
    check("final_fetch_queue", fq.size(), 32'd0);
    check("final_write_queue", wq.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequencer in front of the single-cycle core's 256-word instruction memory. After reset it optionally boot-loads program words into the memory through a valid/ready stream, then owns the program counter. It advances the PC under a fetch handshake, applies branch/jump redirects, and supports halt/resume. It drives the memory write port and the fetch address (`pc_current`) that indexes the memory by word.

Parameters:
- ADDR_W, 8, word-address width of instruction memory (depth 2^ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value after reset and after boot-load completes.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- boot_en  in  1  sampled only in INIT: 1 selects LOAD, 0 selects RUN.
- prog_valid  in  1  program word available.
- prog_data  in  32  program word.
- prog_last  in  1  marks final program word.
- prog_ready  out  1  controller accepts program word.
- mem_we  out  1  instruction-memory write strobe.
- mem_waddr  out  ADDR_W  word address for write.
- mem_wdata  out  32  write data.
- pc_current  out  32  fetch byte address to instruction memory.
- fetch_valid  out  1  `pc_current` is a valid fetch.
- fetch_ready  in  1  downstream consumed the instruction this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  32  target byte address.
- halt_req  in  1  request stop.
- resume  in  1  leave HALT.
- state_o  out  2  INIT=0, LOAD=1, RUN=2, HALT=3.
- misalign_err  out  1  sticky misaligned-redirect flag.
- load_count  out  ADDR_W+1  number of words written in the last boot load.

Behaviour:

Reset (`rst_n` low, asynchronous):
- state=INIT, `pc_current`=RESET_PC, load pointer=0, `load_count`=0, `misalign_err`=0.
- All other outputs 0.

INIT:
- Lasts exactly one cycle after `rst_n` deasserts.
- Next state is LOAD if `boot_en`=1, else RUN.

LOAD:
- `prog_ready`=1 and `fetch_valid`=0.
- `mem_we`=`prog_valid` (combinational); `mem_waddr`=load pointer; `mem_wdata`=`prog_data`.
- On each accept (`prog_valid` & `prog_ready`): pointer+1 and `load_count`+1.
- If the accepted word has `prog_last`=1, or the pointer equals 2^ADDR_W−1: next state RUN, `pc_current`←RESET_PC, pointer←0.
- A full memory therefore ends the load after 2^ADDR_W words with `load_count`=2^ADDR_W. Any `prog_last` after that point is ignored.

RUN:
- `fetch_valid`=1, `prog_ready`=0, `mem_we`=0.
- PC priority, evaluated per cycle:
  1. `redirect_valid` with `redirect_pc[1:0]`≠0: `misalign_err`←1, state←HALT, PC held.
  2. `redirect_valid` aligned: `pc_current`←`redirect_pc`, regardless of `fetch_ready`.
  3. `fetch_ready`: `pc_current`←`pc_current`+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  4. Otherwise the PC is held (stall).
- `halt_req` in the same cycle as an aligned redirect: the redirect is applied, then state←HALT.
- `halt_req` alone: state←HALT, and any `fetch_ready` advance that cycle still applies.

HALT:
- `fetch_valid`=0 and PC held.
- `resume`=1 and `misalign_err`=0: RUN next cycle.
- With `misalign_err`=1, `resume` is ignored; only reset clears the error.
- `redirect_valid` and `halt_req` are ignored in HALT.

General rules:
- `boot_en` is ignored outside INIT.
- Prog inputs are ignored outside LOAD.
- Reset asserted mid-LOAD or mid-RUN aborts immediately. Memory contents are not cleared; the pointer restarts at 0.
- `state_o` reflects the registered state.

Test Plan:
1. `boot_en`=0, `fetch_ready`=1 for 4 cycles → state INIT→RUN; `pc_current` 0,4,8,12,16; `mem_we` never asserted.
2. `boot_en`=1, stream 12 words 0x00100093… with `prog_last` on word 12 and `prog_valid` gaps → writes to addresses 0..11 in order, `load_count`=12, RUN with PC=0 on the cycle after the last accept.
3. RUN at PC=0x24, `redirect_valid` with `redirect_pc`=0x2C while `fetch_ready`=0 → PC=0x2C next cycle. A following `fetch_ready` pulse → 0x30.
4. `redirect_pc`=0x2E → `misalign_err`=1, state HALT, PC unchanged; `resume` pulse → stays HALT; reset → `misalign_err`=0.
5. `halt_req` with `fetch_ready`=1 at PC=8 → PC=12, HALT, `fetch_valid`=0; `resume` → RUN, PC still 12.
6. Boot-load 256 words with no `prog_last` → `load_count`=256, last write to address 255, then RUN. Separately, PC=0xFFFFFFFC with `fetch_ready` → PC=0.
